// File: rtl/demux12_pkg.sv
// demux12_pkg: shared definitions for the demux12 stream demultiplexer.
//   - FSM state encodings and the state enum
//   - packet counter width / saturation value and a saturating increment helper
package demux12_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PKT_A = 2'd1;
  localparam logic [1:0] ST_PKT_B = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    PKT_A = ST_PKT_A,
    PKT_B = ST_PKT_B
  } state_e;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux12_slice.sv
// demux12_slice: one-entry output register slice (VALID/DATA/LAST).
// Ports:
//   clk, rst           clock, async active-high reset
//   load               write a new beat this cycle (wins over drain)
//   ld_data, ld_last   beat to write
//   ready              downstream ready
//   valid, data, last  registered output beat
//   free               slice can take a beat this cycle (!valid || ready)
module demux12_slice
  import demux12_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             last_q,  last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
      last_d  = ld_last;
    end else if (valid_q && ready) begin
      // payload is left in place; only valid drops
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;
  assign free  = !valid_q || ready;

endmodule

// File: rtl/demux12.sv
// demux12: registered, packet-aware 1-to-2 stream demultiplexer.
// The destination (IN_SEL, 0=A 1=B) is taken from the first accepted beat of
// a packet and held until its LAST beat. Each output has a one-entry slice,
// so a beat accepted in cycle n is visible on its output in cycle n+1.
// Ports:
//   CLK, RST                       clock, async active-high reset
//   IN_DATA/SEL/LAST/VALID/READY   input stream
//   A_DATA/LAST/VALID/READY        output A stream
//   B_DATA/LAST/VALID/READY        output B stream
//   A_PKTS, B_PKTS                 saturating delivered-packet counters
//                                  (only when DEMUX12_STATS_EN is defined)
// Optional feature macro: DEMUX12_STATS_EN
module demux12
  import demux12_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_SEL,
  input  logic             IN_LAST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] A_DATA,
  output logic             A_LAST,
  output logic             A_VALID,
  input  logic             A_READY,
  output logic [WIDTH-1:0] B_DATA,
  output logic             B_LAST,
  output logic             B_VALID,
  input  logic             B_READY
`ifdef DEMUX12_STATS_EN
  ,
  output logic [CNT_W-1:0] A_PKTS,
  output logic [CNT_W-1:0] B_PKTS
`endif
);

  state_e state_q, state_d;
  logic   target_b;
  logic   a_free, b_free;
  logic   accept, load_a, load_b;

  // Inside a packet the locked destination wins; IN_SEL only matters in IDLE.
  always_comb begin
    target_b = 1'b0;
    case (state_q)
      IDLE:    target_b = IN_SEL;
      PKT_B:   target_b = 1'b1;
      default: target_b = 1'b0;
    endcase
  end

  assign IN_READY = target_b ? b_free : a_free;
  assign accept   = IN_VALID && IN_READY;
  assign load_a   = accept && !target_b;
  assign load_b   = accept &&  target_b;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE:    if (!IN_LAST) state_d = IN_SEL ? PKT_B : PKT_A;
        default: if (IN_LAST)  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  demux12_slice #(.WIDTH(WIDTH)) u_slice_a (
    .clk     (CLK),
    .rst     (RST),
    .load    (load_a),
    .ld_data (IN_DATA),
    .ld_last (IN_LAST),
    .ready   (A_READY),
    .valid   (A_VALID),
    .data    (A_DATA),
    .last    (A_LAST),
    .free    (a_free)
  );

  demux12_slice #(.WIDTH(WIDTH)) u_slice_b (
    .clk     (CLK),
    .rst     (RST),
    .load    (load_b),
    .ld_data (IN_DATA),
    .ld_last (IN_LAST),
    .ready   (B_READY),
    .valid   (B_VALID),
    .data    (B_DATA),
    .last    (B_LAST),
    .free    (b_free)
  );

`ifdef DEMUX12_STATS_EN
  logic [CNT_W-1:0] a_pkts_q, a_pkts_d;
  logic [CNT_W-1:0] b_pkts_q, b_pkts_d;

  // A packet counts when its LAST beat is written into the slice.
  always_comb begin
    a_pkts_d = a_pkts_q;
    b_pkts_d = b_pkts_q;
    if (load_a && IN_LAST) a_pkts_d = sat_inc(a_pkts_q);
    if (load_b && IN_LAST) b_pkts_d = sat_inc(b_pkts_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_pkts_q <= '0;
      b_pkts_q <= '0;
    end else begin
      a_pkts_q <= a_pkts_d;
      b_pkts_q <= b_pkts_d;
    end
  end

  assign A_PKTS = a_pkts_q;
  assign B_PKTS = b_pkts_q;
`endif

endmodule

// File: tb/tb_demux12.sv
// tb_demux12: directed self-checking bench for demux12.
// Inputs change 1ns after the rising edge; outputs are sampled there too,
// so registered outputs show the result of the preceding edge.
module tb_demux12;
  import demux12_pkg::*;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_SEL, IN_LAST, IN_VALID, IN_READY;
  logic [WIDTH-1:0] A_DATA, B_DATA;
  logic             A_LAST, A_VALID, A_READY;
  logic             B_LAST, B_VALID, B_READY;
`ifdef DEMUX12_STATS_EN
  logic [CNT_W-1:0] A_PKTS, B_PKTS;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  demux12 #(.WIDTH(WIDTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_DATA  (IN_DATA),
    .IN_SEL   (IN_SEL),
    .IN_LAST  (IN_LAST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A_DATA   (A_DATA),
    .A_LAST   (A_LAST),
    .A_VALID  (A_VALID),
    .A_READY  (A_READY),
    .B_DATA   (B_DATA),
    .B_LAST   (B_LAST),
    .B_VALID  (B_VALID),
    .B_READY  (B_READY)
`ifdef DEMUX12_STATS_EN
    ,
    .A_PKTS   (A_PKTS),
    .B_PKTS   (B_PKTS)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic s, input logic l);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_SEL   = s;
    IN_LAST  = l;
  endtask

  task automatic idle();
    IN_VALID = 1'b0;
    IN_DATA  = 8'h5A;
    IN_SEL   = 1'b1;
    IN_LAST  = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    A_READY = 1'b1;
    B_READY = 1'b1;

    // 1. reset
    #3;
    chk("rst_a_valid", {31'd0, A_VALID}, 32'd0);
    chk("rst_b_valid", {31'd0, B_VALID}, 32'd0);
    chk("rst_a_data", {24'd0, A_DATA}, 32'd0);
    chk("rst_b_data", {24'd0, B_DATA}, 32'd0);
    #14 RST = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    tick();

    // 2. single beats
    drive(8'h11, 1'b0, 1'b1);
    #1 chk("single_rdy_a", {31'd0, IN_READY}, 32'd1);
    tick();
    chk("single_a_valid", {31'd0, A_VALID}, 32'd1);
    chk("single_a_data", {24'd0, A_DATA}, 32'h11);
    chk("single_a_last", {31'd0, A_LAST}, 32'd1);
    chk("single_b_idle", {31'd0, B_VALID}, 32'd0);
    drive(8'h22, 1'b1, 1'b1);
    tick();
    chk("single_b_valid", {31'd0, B_VALID}, 32'd1);
    chk("single_b_data", {24'd0, B_DATA}, 32'h22);
    chk("single_a_drained", {31'd0, A_VALID}, 32'd0);

    // 3. packet lock on A
    drive(8'hA0, 1'b0, 1'b0);
    tick();
    chk("lock_a0", {23'd0, A_VALID, A_DATA}, {23'd0, 1'b1, 8'hA0});
    drive(8'hA1, 1'b1, 1'b0);
    #1 chk("lock_rdy", {31'd0, IN_READY}, 32'd1);
    tick();
    chk("lock_a1", {23'd0, A_VALID, A_DATA}, {23'd0, 1'b1, 8'hA1});
    chk("lock_b1", {31'd0, B_VALID}, 32'd0);
    drive(8'hA2, 1'b1, 1'b1);
    tick();
    chk("lock_a2", {22'd0, A_VALID, A_LAST, A_DATA}, {22'd0, 1'b1, 1'b1, 8'hA2});
    chk("lock_b2", {31'd0, B_VALID}, 32'd0);
    idle();
    tick();
    chk("lock_a_empty", {31'd0, A_VALID}, 32'd0);

    // 4. backpressure on A while B flows
    A_READY = 1'b0;
    drive(8'h30, 1'b0, 1'b1);
    tick();
    chk("bp_a_hold", {23'd0, A_VALID, A_DATA}, {23'd0, 1'b1, 8'h30});
    drive(8'h31, 1'b0, 1'b1);
    #1 chk("bp_in_ready", {31'd0, IN_READY}, 32'd0);
    tick();
    chk("bp_a_stable", {23'd0, A_VALID, A_DATA}, {23'd0, 1'b1, 8'h30});
    drive(8'h40, 1'b1, 1'b0);
    #1 chk("bp_b_ready", {31'd0, IN_READY}, 32'd1);
    tick();
    chk("bp_b0", {23'd0, B_VALID, B_DATA}, {23'd0, 1'b1, 8'h40});
    drive(8'h41, 1'b0, 1'b1);
    tick();
    chk("bp_b1", {22'd0, B_VALID, B_LAST, B_DATA}, {22'd0, 1'b1, 1'b1, 8'h41});
    chk("bp_a_still", {23'd0, A_VALID, A_DATA}, {23'd0, 1'b1, 8'h30});
    idle();
    A_READY = 1'b1;
    tick();
    chk("bp_a_release", {31'd0, A_VALID}, 32'd0);
    chk("bp_b_release", {31'd0, B_VALID}, 32'd0);

    // 5. reset mid-packet on B
    drive(8'h50, 1'b1, 1'b0);
    tick();
    chk("mid_b0", {23'd0, B_VALID, B_DATA}, {23'd0, 1'b1, 8'h50});
    drive(8'h51, 1'b1, 1'b0);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_b", {23'd0, B_VALID, B_DATA}, 32'd0);
    RST = 1'b0;
    drive(8'h60, 1'b0, 1'b1);
    #1 chk("mid_rdy", {31'd0, IN_READY}, 32'd1);
    tick();
    chk("mid_to_a", {23'd0, A_VALID, A_DATA}, {23'd0, 1'b1, 8'h60});
    chk("mid_not_b", {31'd0, B_VALID}, 32'd0);
    idle();
    tick();

`ifdef DEMUX12_STATS_EN
    // 6. packet counters
    RST = 1'b1;
    #2 RST = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(8'(i), 1'b0, 1'b1);
      tick();
    end
    drive(8'h70, 1'b1, 1'b0);
    tick();
    drive(8'h71, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(8'(i), 1'b1, 1'b1);
      tick();
    end
    idle();
    tick();
    chk("stats_a5", {16'd0, A_PKTS}, 32'd5);
    chk("stats_b3", {16'd0, B_PKTS}, 32'd3);
    drive(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 65530; i++) tick();
    idle();
    tick();
    chk("stats_a_max", {16'd0, A_PKTS}, 32'h0000FFFF);
    drive(8'h01, 1'b0, 1'b1);
    tick();
    tick();
    idle();
    tick();
    chk("stats_a_sat", {16'd0, A_PKTS}, 32'h0000FFFF);
    chk("stats_b_same", {16'd0, B_PKTS}, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
